axi_apb_burst_sched: RTL and testbench
======================================

// Module: axi_apb_burst_sched
// PURPOSE
// - Burst scheduler of the AXI-APB bridge. Sits between the AXI slave front end and the APB master FSM.
// - Front end holds one decoded write command (AW) and one decoded read command (AR).
// - Arbitrates round-robin between them at burst granularity.
// - Expands the granted burst into single-beat APB transfer requests (FIXED/INCR/WRAP addressing).
// PARAMETERS
// ADDR_W      32   address width
// ID_W        4    AXI ID width
// DATA_W      32   bus data width; MAX_SIZE = log2(DATA_W/8)
// PORTS
// aclk          in   1       clock
// aresetn       in   1       async active-low reset
// wr_cmd_valid  in   1       write command pending
// wr_cmd_ready  out  1       write command accepted (granted)
// wr_cmd_id     in   ID_W    AWID
// wr_cmd_addr   in   ADDR_W  AWADDR
// wr_cmd_len    in   8       AWLEN (beats-1)
// wr_cmd_size   in   3       AWSIZE
// wr_cmd_burst  in   2       AWBURST
// rd_cmd_*      in/out       same set as wr_cmd_*, for AR
// beat_valid    out  1       beat request to APB master
// beat_ready    in   1       APB master accepts beat
// beat_write    out  1       1=write beat, 0=read beat
// beat_addr     out  ADDR_W  beat byte address
// beat_id       out  ID_W    ID of owning burst
// beat_last     out  1       final beat of burst
// sched_busy    out  1       burst in progress
// BEHAVIOUR
// - Reset (async, aresetn=0), outputs and state:
//   - state=IDLE; all outputs 0; rr_ptr=WRITE (write wins first tie); beat counter 0.
//   - Reset mid-burst: beat_valid drops immediately; the partial burst is discarded.
// - FSM IDLE->BURST:
//   - In IDLE, grant one of wr/rd if valid. Both valid -> grant rr_ptr side.
//   - The granted cmd_ready is high for exactly that cycle; the command is latched.
//   - rr_ptr flips to the other side.
// - FSM BURST->IDLE:
//   - On beat_valid&beat_ready&beat_last.
//   - Exactly one idle cycle between consecutive bursts.
// - cmd_ready is never high in BURST. wr_cmd_ready and rd_cmd_ready are never high together.
// - Latency:
//   - Command accepted in cycle N -> first beat_valid in N+1.
//   - Beat k+1 is valid the cycle after beat k handshake; no bubble inside a burst.
// - Handshake:
//   - beat_valid stays high, and beat_addr/id/write/last stay stable, until beat_ready.
//   - beat_valid does not depend combinationally on beat_ready.
// - Beat count:
//   - Counter 0..len; beat_last = (cnt==len). len=0 -> single beat with last=1.
// - Size clamp:
//   - bytes = 1<<min(size, MAX_SIZE); size>MAX_SIZE is clamped.
// - Next address per burst type:
//   - FIXED (00): address constant.
//   - INCR (01), and reserved 11: next = (addr & ~(bytes-1)) + bytes, modulo 2^ADDR_W (wraps past all-ones). The first beat uses the unaligned start address.
//   - WRAP (10), len in {1,3,7,15}:
//     - wsz = bytes*(len+1); low = start & ~(wsz-1).
//     - next = addr+bytes; if next == low+wsz then next = low.
//     - WRAP with any other len is handled as INCR.
// - 4KB-crossing and protocol-error checks belong to the front end; not checked here.
// - sched_busy = (state==BURST).
// STRUCTURE
// - Shared package axi_apb_pkg:
//   - burst_e {FIXED, INCR, WRAP, RSVD}
//   - sched_state_e {IDLE, BURST}
//   - cmd_t struct {id, addr, len, size, burst}
// - Sub-module axi_apb_addr_gen: combinational next-address (addr, start, size, len, burst -> next).
// - Parent owns FSM, arbiter, counter, latched cmd_t.
// TESTING
// - Write only: wr addr=0x100 len=3 size=2 INCR, beat_ready=1.
//   -> wr_cmd_ready pulse at N; beats N+1..N+4 at 0x100,104,108,10C; last on 4th.
// - WRAP: rd addr=0x38 len=3 size=2.
//   -> beat addrs 0x38,0x3C,0x30,0x34; beat_write=0.
// - Tie after reset: wr+rd valid together.
//   -> write granted first, then read after 1 idle cycle, then write again if still pending.
// - Backpressure: beat_ready low for 3 cycles on beat 2 of INCR len=1.
//   -> beat_valid/addr/last held stable; completes on first ready.
// - Unaligned/clamp: INCR addr=0x103 size=2 len=2 -> 0x103,0x104,0x108.
//   INCR addr=0xFFFFFFFC size=3 (DATA_W=32) -> clamped size 2; beat 2 at 0x00000000.
// - Reset mid-burst: aresetn low during beat 2 of len=7.
//   -> beat_valid 0 asynchronously; after release IDLE; next tie grants write.

Source files
------------

// File: rtl/axi_apb_burst_sched_pkg.sv
// Shared types for the AXI-APB bridge burst scheduler: burst encodings,
// scheduler states and the latched command record.
package axi_apb_pkg;

  localparam int unsigned CMD_ADDR_W = 32;
  localparam int unsigned CMD_ID_W   = 4;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [CMD_ID_W-1:0]   id;
    logic [CMD_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    burst_e                burst;
  } cmd_t;

endpackage

// File: rtl/axi_apb_burst_sched_if.sv
// Command and beat handshake bundle between the AXI front end, the burst
// scheduler and the APB master FSM.
interface axi_apb_burst_sched_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
);

  logic              wr_cmd_valid;
  logic              wr_cmd_ready;
  logic [ID_W-1:0]   wr_cmd_id;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [7:0]        wr_cmd_len;
  logic [2:0]        wr_cmd_size;
  logic [1:0]        wr_cmd_burst;

  logic              rd_cmd_valid;
  logic              rd_cmd_ready;
  logic [ID_W-1:0]   rd_cmd_id;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [7:0]        rd_cmd_len;
  logic [2:0]        rd_cmd_size;
  logic [1:0]        rd_cmd_burst;

  logic              beat_valid;
  logic              beat_ready;
  logic              beat_write;
  logic [ADDR_W-1:0] beat_addr;
  logic [ID_W-1:0]   beat_id;
  logic              beat_last;

  // Scheduler side: accepts commands, issues beats.
  modport master (
    input  wr_cmd_valid, wr_cmd_id, wr_cmd_addr, wr_cmd_len, wr_cmd_size, wr_cmd_burst,
    input  rd_cmd_valid, rd_cmd_id, rd_cmd_addr, rd_cmd_len, rd_cmd_size, rd_cmd_burst,
    output wr_cmd_ready, rd_cmd_ready,
    output beat_valid, beat_write, beat_addr, beat_id, beat_last,
    input  beat_ready
  );

  // Front end / APB side: presents commands, consumes beats.
  modport slave (
    output wr_cmd_valid, wr_cmd_id, wr_cmd_addr, wr_cmd_len, wr_cmd_size, wr_cmd_burst,
    output rd_cmd_valid, rd_cmd_id, rd_cmd_addr, rd_cmd_len, rd_cmd_size, rd_cmd_burst,
    input  wr_cmd_ready, rd_cmd_ready,
    input  beat_valid, beat_write, beat_addr, beat_id, beat_last,
    output beat_ready
  );

endinterface

// File: rtl/axi_apb_burst_sched_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts, with the
// transfer size clamped to the bus width.
module axi_apb_addr_gen
  import axi_apb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] start,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  burst_e            burst,
  output logic [ADDR_W-1:0] next
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_W / 8);

  logic [2:0]        eff_size;
  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] wsz;
  logic [ADDR_W-1:0] low;
  logic [ADDR_W-1:0] incr_next;
  logic [ADDR_W-1:0] wrap_next;
  logic              wrap_ok;

  always_comb begin
    eff_size  = (size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size;
    bytes     = ADDR_W'(1) << eff_size;
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    wsz       = bytes * (ADDR_W'(len) + ADDR_W'(1));
    low       = start & ~(wsz - ADDR_W'(1));
    // INCR realigns after the (possibly unaligned) first beat.
    incr_next = (addr & ~(bytes - ADDR_W'(1))) + bytes;
    wrap_next = addr + bytes;
    if (wrap_next == (low + wsz)) begin
      wrap_next = low;
    end
    unique case (burst)
      FIXED:   next = addr;
      WRAP:    next = wrap_ok ? wrap_next : incr_next;
      default: next = incr_next;
    endcase
  end

endmodule

// File: rtl/axi_apb_burst_sched.sv
// Burst scheduler: round-robin between the pending AW and AR commands at
// burst granularity, then expands the granted burst into APB beat requests.
module axi_apb_burst_sched
  import axi_apb_pkg::*;
#(
  parameter int unsigned ADDR_W = CMD_ADDR_W,
  parameter int unsigned ID_W   = CMD_ID_W,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axi_apb_burst_sched_if.master  bus,
  output logic                   sched_busy
);

  sched_state_e      state;
  cmd_t              cmd;
  cmd_t              sel_cmd;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        cnt;
  logic              is_write;
  logic              rr_wr;
  logic              idle;
  logic              grant_wr;
  logic              grant_rd;
  logic              in_burst;

  // Grants are combinational in IDLE so the accept cycle is the single idle
  // cycle between bursts; held off while reset is asserted.
  always_comb begin
    idle     = (state == IDLE) && aresetn;
    grant_wr = idle && bus.wr_cmd_valid && (!bus.rd_cmd_valid || rr_wr);
    grant_rd = idle && bus.rd_cmd_valid && (!bus.wr_cmd_valid || !rr_wr);
  end

  always_comb begin
    sel_cmd = '0;
    if (grant_rd) begin
      sel_cmd.id    = bus.rd_cmd_id;
      sel_cmd.addr  = bus.rd_cmd_addr;
      sel_cmd.len   = bus.rd_cmd_len;
      sel_cmd.size  = bus.rd_cmd_size;
      sel_cmd.burst = burst_e'(bus.rd_cmd_burst);
    end else begin
      sel_cmd.id    = bus.wr_cmd_id;
      sel_cmd.addr  = bus.wr_cmd_addr;
      sel_cmd.len   = bus.wr_cmd_len;
      sel_cmd.size  = bus.wr_cmd_size;
      sel_cmd.burst = burst_e'(bus.wr_cmd_burst);
    end
  end

  axi_apb_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_addr_gen (
    .addr  (cur_addr),
    .start (cmd.addr),
    .size  (cmd.size),
    .len   (cmd.len),
    .burst (cmd.burst),
    .next  (next_addr)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      cmd      <= '0;
      cur_addr <= '0;
      cnt      <= '0;
      is_write <= 1'b0;
      rr_wr    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            state    <= BURST;
            cmd      <= sel_cmd;
            cur_addr <= sel_cmd.addr;
            cnt      <= '0;
            is_write <= grant_wr;
            rr_wr    <= grant_rd;
          end
        end
        BURST: begin
          if (bus.beat_ready) begin
            if (cnt == cmd.len) begin
              state <= IDLE;
            end else begin
              cnt      <= cnt + 8'd1;
              cur_addr <= next_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_burst         = (state == BURST);
  assign sched_busy       = in_burst;
  assign bus.wr_cmd_ready = grant_wr;
  assign bus.rd_cmd_ready = grant_rd;
  assign bus.beat_valid   = in_burst;
  assign bus.beat_write   = is_write;
  assign bus.beat_addr    = cur_addr;
  assign bus.beat_id      = cmd.id;
  assign bus.beat_last    = in_burst && (cnt == cmd.len);

endmodule

// File: tb/tb_axi_apb_burst_sched.sv
// Bench for axi_apb_burst_sched: directed burst table, corner sequences and a
// randomized run against an arithmetic address / round-robin model.
module tb_axi_apb_burst_sched;
  import axi_apb_pkg::*;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_SIZE = 2;
  localparam int unsigned NV       = 8;
  localparam int unsigned N_RAND   = 30;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic sched_busy;

  axi_apb_burst_sched_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  axi_apb_burst_sched #(
    .ADDR_W (ADDR_W),
    .ID_W   (ID_W),
    .DATA_W (DATA_W)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .bus        (bus),
    .sched_busy (sched_busy)
  );

  always #5 aclk = ~aclk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic        is_wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0][31:0] exp_addr;
  } vec_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } rcmd_t;

  typedef struct packed {
    logic        w;
    logic [3:0]  id;
    logic [31:0] addr;
    logic        last;
  } beat_t;

  function automatic vec_t mk(input logic is_wr, input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.is_wr = is_wr; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    return v;
  endfunction

  // k-th beat address straight from the burst rules (modular arithmetic for WRAP).
  function automatic logic [31:0] m_addr(input logic [31:0] start, input logic [2:0] size,
                                         input logic [7:0] len, input logic [1:0] burst,
                                         input int unsigned k);
    logic [31:0] bytes, wsz, low;
    int unsigned sz;
    sz    = (32'(size) > MAX_SIZE) ? MAX_SIZE : 32'(size);
    bytes = 32'(1) << sz;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      wsz = bytes * (32'(len) + 32'd1);
      low = (start / wsz) * wsz;
      return low + ((start - low + 32'(k) * bytes) % wsz);
    end
    if (k == 0) return start;
    return (start / bytes) * bytes + 32'(k) * bytes;
  endfunction

  function automatic rcmd_t rand_cmd();
    rcmd_t c;
    logic [31:0] bytes;
    c.id    = 4'($urandom);
    c.size  = 3'($urandom_range(0, 7));
    c.burst = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       c.len = (8'd2 << $urandom_range(0, 3)) - 8'd1;
      1:       c.len = 8'd0;
      2:       c.len = 8'($urandom_range(0, 8));
      default: c.len = 8'($urandom_range(0, 16));
    endcase
    c.addr = $urandom;
    if ($urandom_range(0, 7) == 0) c.addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    bytes = 32'(1) << ((32'(c.size) > MAX_SIZE) ? MAX_SIZE : 32'(c.size));
    if (c.burst == 2'b10) c.addr = (c.addr / bytes) * bytes;
    return c;
  endfunction

  task automatic clear_inputs();
    bus.wr_cmd_valid = 1'b0; bus.wr_cmd_id = '0; bus.wr_cmd_addr = '0;
    bus.wr_cmd_len = '0; bus.wr_cmd_size = '0; bus.wr_cmd_burst = '0;
    bus.rd_cmd_valid = 1'b0; bus.rd_cmd_id = '0; bus.rd_cmd_addr = '0;
    bus.rd_cmd_len = '0; bus.rd_cmd_size = '0; bus.rd_cmd_burst = '0;
    bus.beat_ready = 1'b0;
  endtask

  task automatic drive_cmd(input logic is_wr, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    if (is_wr) begin
      bus.wr_cmd_valid = 1'b1; bus.wr_cmd_id = id; bus.wr_cmd_addr = addr;
      bus.wr_cmd_len = len; bus.wr_cmd_size = size; bus.wr_cmd_burst = burst;
    end else begin
      bus.rd_cmd_valid = 1'b1; bus.rd_cmd_id = id; bus.rd_cmd_addr = addr;
      bus.rd_cmd_len = len; bus.rd_cmd_size = size; bus.rd_cmd_burst = burst;
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  vec_t  tbl [NV];
  beat_t exp_q [$];
  rcmd_t wp, rp;
  bit    wp_v, rp_v, pref_wr, exp_idle, exp_wg, exp_rg, done;
  int unsigned grants;

  initial begin
    tbl[0] = mk(1'b1, 4'h1, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 32'h100, 32'h104, 32'h108, 32'h10C);
    tbl[1] = mk(1'b0, 4'h2, 32'h0000_0038, 8'd3, 3'd2, 2'b10, 32'h038, 32'h03C, 32'h030, 32'h034);
    tbl[2] = mk(1'b1, 4'h3, 32'h0000_0103, 8'd2, 3'd2, 2'b01, 32'h103, 32'h104, 32'h108, 32'h0);
    tbl[3] = mk(1'b1, 4'h4, 32'hFFFF_FFFC, 8'd1, 3'd3, 2'b01, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
    tbl[4] = mk(1'b0, 4'h5, 32'h0000_0020, 8'd0, 3'd2, 2'b00, 32'h020, 32'h0, 32'h0, 32'h0);
    tbl[5] = mk(1'b1, 4'h6, 32'h0000_0044, 8'd2, 3'd1, 2'b00, 32'h044, 32'h044, 32'h044, 32'h0);
    tbl[6] = mk(1'b0, 4'h7, 32'h0000_0010, 8'd2, 3'd1, 2'b10, 32'h010, 32'h012, 32'h014, 32'h0);
    tbl[7] = mk(1'b1, 4'h8, 32'h0000_001F, 8'd3, 3'd0, 2'b11, 32'h01F, 32'h020, 32'h021, 32'h022);

    // Reset with both commands asserted: every output must stay low.
    clear_inputs();
    bus.wr_cmd_valid = 1'b1;
    bus.rd_cmd_valid = 1'b1;
    bus.beat_ready   = 1'b1;
    #2;
    chk("rst_wr_ready", 64'(bus.wr_cmd_ready), 64'(0));
    chk("rst_rd_ready", 64'(bus.rd_cmd_ready), 64'(0));
    chk("rst_beat_valid", 64'(bus.beat_valid), 64'(0));
    chk("rst_beat_out", 64'({bus.beat_write, bus.beat_id, bus.beat_addr, bus.beat_last}), 64'(0));
    chk("rst_busy", 64'(sched_busy), 64'(0));
    do_reset();

    // Tie straight after reset: write, one idle/grant cycle, read, then write again.
    @(negedge aclk);
    drive_cmd(1'b1, 4'h2, 32'h400, 8'd0, 3'd2, 2'b01);
    drive_cmd(1'b0, 4'h5, 32'h500, 8'd0, 3'd2, 2'b01);
    bus.beat_ready = 1'b1;
    #1;
    chk("tie_wr_ready", 64'({bus.wr_cmd_ready, bus.rd_cmd_ready}), 64'(2'b10));
    @(negedge aclk);
    chk("tie_beat_wr", 64'({bus.beat_valid, bus.beat_write, bus.beat_id, bus.beat_addr, bus.beat_last}),
        64'({1'b1, 1'b1, 4'h2, 32'h400, 1'b1}));
    chk("tie_no_ready_in_burst", 64'({bus.wr_cmd_ready, bus.rd_cmd_ready}), 64'(0));
    @(negedge aclk);
    chk("tie_gap_valid", 64'(bus.beat_valid), 64'(0));
    chk("tie_rd_ready", 64'({bus.wr_cmd_ready, bus.rd_cmd_ready}), 64'(2'b01));
    @(negedge aclk);
    chk("tie_beat_rd", 64'({bus.beat_valid, bus.beat_write, bus.beat_id, bus.beat_addr, bus.beat_last}),
        64'({1'b1, 1'b0, 4'h5, 32'h500, 1'b1}));
    @(negedge aclk);
    chk("tie_wr_again", 64'({bus.wr_cmd_ready, bus.rd_cmd_ready, bus.beat_valid}), 64'(3'b100));
    clear_inputs();
    @(negedge aclk);
    chk("tie_end_busy", 64'(sched_busy), 64'(0));

    // Directed burst table, beat_ready held high.
    for (int i = 0; i < int'(NV); i++) begin
      vec_t v;
      v = tbl[i];
      @(negedge aclk);
      drive_cmd(v.is_wr, v.id, v.addr, v.len, v.size, v.burst);
      bus.beat_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", i), 64'({bus.wr_cmd_ready, bus.rd_cmd_ready}),
          64'(v.is_wr ? 2'b10 : 2'b01));
      chk($sformatf("v%0d_idle_busy", i), 64'(sched_busy), 64'(0));
      @(negedge aclk);
      clear_inputs();
      bus.beat_ready = 1'b1;
      for (int k = 0; k <= int'(v.len); k++) begin
        if (k > 0) @(negedge aclk);
        chk($sformatf("v%0d_beat%0d", i, k),
            64'({bus.beat_valid, bus.beat_write, bus.beat_id, bus.beat_addr, bus.beat_last}),
            64'({1'b1, v.is_wr, v.id, v.exp_addr[k], (k == int'(v.len))}));
      end
      @(negedge aclk);
      chk($sformatf("v%0d_done", i), 64'({bus.beat_valid, sched_busy}), 64'(0));
    end

    // Backpressure on beat 2 of INCR len=1.
    @(negedge aclk);
    drive_cmd(1'b1, 4'h3, 32'h200, 8'd1, 3'd2, 2'b01);
    bus.beat_ready = 1'b1;
    @(negedge aclk);
    clear_inputs();
    bus.beat_ready = 1'b1;
    chk("bp_beat0", 64'({bus.beat_valid, bus.beat_addr, bus.beat_last}), 64'({1'b1, 32'h200, 1'b0}));
    @(negedge aclk);
    bus.beat_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge aclk);
      chk($sformatf("bp_hold%0d", c),
          64'({bus.beat_valid, bus.beat_write, bus.beat_id, bus.beat_addr, bus.beat_last}),
          64'({1'b1, 1'b1, 4'h3, 32'h204, 1'b1}));
    end
    bus.beat_ready = 1'b1;
    @(negedge aclk);
    chk("bp_done", 64'({bus.beat_valid, sched_busy}), 64'(0));

    // Reset mid-burst (write, so rr points at read), then a tie must grant write.
    @(negedge aclk);
    drive_cmd(1'b1, 4'h7, 32'h600, 8'd7, 3'd2, 2'b01);
    bus.beat_ready = 1'b1;
    @(negedge aclk);
    clear_inputs();
    bus.beat_ready = 1'b1;
    @(negedge aclk);
    chk("mrst_beat1", 64'({bus.beat_valid, bus.beat_addr}), 64'({1'b1, 32'h604}));
    bus.beat_ready = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("mrst_valid_drop", 64'({bus.beat_valid, sched_busy, bus.beat_last}), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    drive_cmd(1'b1, 4'h1, 32'h700, 8'd0, 3'd2, 2'b01);
    drive_cmd(1'b0, 4'h2, 32'h800, 8'd0, 3'd2, 2'b01);
    bus.beat_ready = 1'b1;
    #1;
    chk("mrst_tie_wr", 64'({bus.wr_cmd_ready, bus.rd_cmd_ready}), 64'(2'b10));
    @(negedge aclk);
    clear_inputs();
    chk("mrst_tie_beat", 64'({bus.beat_valid, bus.beat_write, bus.beat_addr}), 64'({1'b1, 1'b1, 32'h700}));

    // Randomized traffic against the reference model.
    do_reset();
    wp_v = 1'b0; rp_v = 1'b0; pref_wr = 1'b1; grants = 0; done = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      @(negedge aclk);
      if (grants < N_RAND && !wp_v && $urandom_range(0, 2) == 0) begin wp = rand_cmd(); wp_v = 1'b1; end
      if (grants < N_RAND && !rp_v && $urandom_range(0, 2) == 0) begin rp = rand_cmd(); rp_v = 1'b1; end
      clear_inputs();
      if (wp_v) drive_cmd(1'b1, wp.id, wp.addr, wp.len, wp.size, wp.burst);
      if (rp_v) drive_cmd(1'b0, rp.id, rp.addr, rp.len, rp.size, rp.burst);
      bus.beat_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_idle = (exp_q.size() == 0);
      exp_wg   = exp_idle && wp_v && (!rp_v || pref_wr);
      exp_rg   = exp_idle && rp_v && !exp_wg;
      chk("rand_ready", 64'({bus.wr_cmd_ready, bus.rd_cmd_ready}), 64'({exp_wg, exp_rg}));
      chk("rand_valid", 64'({bus.beat_valid, sched_busy}), 64'({!exp_idle, !exp_idle}));
      if (!exp_idle) begin
        chk("rand_beat", 64'({bus.beat_write, bus.beat_id, bus.beat_addr, bus.beat_last}), 64'(exp_q[0]));
        if (bus.beat_ready) void'(exp_q.pop_front());
      end
      if (exp_wg || exp_rg) begin
        rcmd_t c;
        c = exp_wg ? wp : rp;
        for (int k = 0; k <= int'(c.len); k++)
          exp_q.push_back('{exp_wg, c.id, m_addr(c.addr, c.size, c.len, c.burst, k), (k == int'(c.len))});
        if (exp_wg) wp_v = 1'b0; else rp_v = 1'b0;
        pref_wr = exp_rg;
        grants++;
      end
      done = (grants >= N_RAND) && (exp_q.size() == 0) && !wp_v && !rp_v;
    end
    chk("rand_completed", 64'(done), 64'(1));
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
